mem_stage_lsu: RTL

- MEM-stage load/store unit: the consumer end of the EX→MEM valid/ready pipeline handshake.
- Accepts one instruction at a time from the EX/MEM register and issues at most one data-memory request over a req/resp handshake.
- Formats load data and presents a registered result to the MEM/WB register.
- Drives ts_ready back to EX/MEM, so memory latency back-pressures the pipeline.

---
 rtl/lsu_pkg.sv | 57 +++++
 rtl/mem_stage_lsu_if.sv | 52 +++++
 rtl/lsu_align.sv | 61 ++++++
 rtl/mem_stage_lsu.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and op-decoding helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [3:0] {
    LSU_NONE  = 4'd0,
    LSU_LD_B  = 4'd1,
    LSU_LD_H  = 4'd2,
    LSU_LD_W  = 4'd3,
    LSU_LD_BU = 4'd4,
    LSU_LD_HU = 4'd5,
    LSU_ST_B  = 4'd6,
    LSU_ST_H  = 4'd7,
    LSU_ST_W  = 4'd8
  } lsu_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Encodings above LSU_ST_W are not ops; they behave like a plain ALU result.
  function automatic lsu_op_t to_op(input logic [3:0] raw);
    lsu_op_t op;
    if (raw <= 4'd8) op = lsu_op_t'(raw);
    else             op = LSU_NONE;
    return op;
  endfunction

  function automatic logic is_load(input lsu_op_t op);
    return (op == LSU_LD_B) || (op == LSU_LD_H) || (op == LSU_LD_W) ||
           (op == LSU_LD_BU) || (op == LSU_LD_HU);
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    return (op == LSU_ST_B) || (op == LSU_ST_H) || (op == LSU_ST_W);
  endfunction

  function automatic lsu_size_t size(input lsu_op_t op);
    lsu_size_t sz;
    case (op)
      LSU_LD_H, LSU_LD_HU, LSU_ST_H: sz = SZ_H;
      LSU_LD_W, LSU_ST_W:            sz = SZ_W;
      default:                       sz = SZ_B;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Pipeline (EX/MEM -> LSU -> MEM/WB) and data-memory signals of the MEM-stage LSU.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  // Every channel here is valid/ready: a transfer happens on a rising clock
  // edge where both are 1; the sender holds payload stable while valid=1 and
  // ready=0, and valid never depends combinationally on ready.
  logic              ls_valid;
  logic              ts_ready;
  logic              ns_ready;
  logic              ts_valid;
  logic              flush;
  logic [31:0]       in_inst;
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_ex_result;
  logic              in_rw_en;
  logic [REG_AW-1:0] in_rw_addr;
  logic [DATA_W-1:0] in_lsu_data;
  logic [3:0]        in_lsu_op;
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [3:0]        dmem_wstrb;
  logic              dmem_resp_valid;
  logic [DATA_W-1:0] dmem_rdata;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [REG_AW-1:0] out_rw_addr;
  logic              out_rw_en;
  logic [DATA_W-1:0] out_result;
  logic              out_ale;

  modport slave (
    input  ls_valid, ns_ready, flush, in_inst, in_pc, in_ex_result, in_rw_en,
           in_rw_addr, in_lsu_data, in_lsu_op, dmem_req_ready, dmem_resp_valid,
           dmem_rdata,
    output ts_ready, ts_valid, dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
           dmem_wstrb, out_inst, out_pc, out_rw_addr, out_rw_en, out_result, out_ale
  );

  modport master (
    output ls_valid, ns_ready, flush, in_inst, in_pc, in_ex_result, in_rw_en,
           in_rw_addr, in_lsu_data, in_lsu_op, dmem_req_ready, dmem_resp_valid,
           dmem_rdata,
    input  ts_ready, ts_valid, dmem_req_valid, dmem_we, dmem_addr, dmem_wdata,
           dmem_wstrb, out_inst, out_pc, out_rw_addr, out_rw_en, out_result, out_ale
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store replication and strobes, load extract/extend, alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_t     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  input  lsu_op_t     chk_op_i,
  input  logic [1:0]  chk_off_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] ldata_o,
  output logic        misaligned_o
);
  logic [31:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    case (op_i)
      LSU_ST_B: begin
        wdata_o = {4{sdata_i[7:0]}};
        wstrb_o = 4'b0001 << off_i;
      end
      LSU_ST_H: begin
        wdata_o = {2{sdata_i[15:0]}};
        wstrb_o = 4'b0011 << off_i;
      end
      LSU_ST_W: begin
        wdata_o = sdata_i;
        wstrb_o = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    ldata_o = '0;
    case (op_i)
      LSU_LD_B:  ldata_o = {{24{shifted[7]}}, shifted[7:0]};
      LSU_LD_BU: ldata_o = {24'b0, shifted[7:0]};
      LSU_LD_H:  ldata_o = {{16{shifted[15]}}, shifted[15:0]};
      LSU_LD_HU: ldata_o = {16'b0, shifted[15:0]};
      LSU_LD_W:  ldata_o = shifted;
      default: ;
    endcase
  end

  // Checked on the incoming op, before it is latched, so ALE never issues a request.
  always_comb begin
    misaligned_o = 1'b0;
    case (size(chk_op_i))
      SZ_H:    misaligned_o = chk_off_i[0];
      SZ_W:    misaligned_o = (chk_off_i != 2'b00);
      default: misaligned_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one instruction from EX/MEM, performs at most
// one data-memory access, and holds a registered result for MEM/WB.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave lsu,
  output lsu_state_t     dbg_state_o
);
  lsu_state_t        state_q, state_d;
  lsu_op_t           op_q, op_d, in_op;
  logic [ADDR_W-1:0] addr_q, addr_d, pc_q, pc_d;
  logic [DATA_W-1:0] sdata_q, sdata_d, result_q, result_d;
  logic [31:0]       inst_q, inst_d;
  logic [REG_AW-1:0] rw_addr_q, rw_addr_d;
  logic              rw_en_q, rw_en_d, ale_q, ale_d;
  logic              ts_ready, accept, in_misaligned;
  logic [DATA_W-1:0] ld_data, st_wdata;
  logic [3:0]        st_wstrb;

  assign in_op = to_op(lsu.in_lsu_op);

  lsu_align u_align (
    .op_i        (op_q),
    .off_i       (addr_q[1:0]),
    .sdata_i     (sdata_q),
    .rdata_i     (lsu.dmem_rdata),
    .chk_op_i    (in_op),
    .chk_off_i   (lsu.in_ex_result[1:0]),
    .wdata_o     (st_wdata),
    .wstrb_o     (st_wstrb),
    .ldata_o     (ld_data),
    .misaligned_o(in_misaligned)
  );

  assign ts_ready = !lsu.flush &&
                    ((state_q == S_IDLE) || ((state_q == S_HOLD) && lsu.ns_ready));
  assign accept   = lsu.ls_valid && ts_ready;

  assign lsu.ts_ready       = ts_ready;
  assign lsu.ts_valid       = (state_q == S_HOLD);
  assign lsu.dmem_req_valid = (state_q == S_REQ);
  assign lsu.dmem_we        = is_store(op_q);
  assign lsu.dmem_addr      = addr_q;
  assign lsu.dmem_wdata     = st_wdata;
  assign lsu.dmem_wstrb     = st_wstrb;
  assign lsu.out_inst       = inst_q;
  assign lsu.out_pc         = pc_q;
  assign lsu.out_rw_addr    = rw_addr_q;
  assign lsu.out_rw_en      = rw_en_q;
  assign lsu.out_result     = result_q;
  assign lsu.out_ale        = ale_q;
  assign dbg_state_o        = state_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    pc_d      = pc_q;
    sdata_d   = sdata_q;
    inst_d    = inst_q;
    rw_addr_d = rw_addr_q;
    rw_en_d   = rw_en_q;
    result_d  = result_q;
    ale_d     = ale_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (lsu.flush) begin
          state_d = S_IDLE;
        end else if (accept) begin
          op_d      = in_op;
          addr_d    = lsu.in_ex_result[ADDR_W-1:0];
          pc_d      = lsu.in_pc;
          sdata_d   = lsu.in_lsu_data;
          inst_d    = lsu.in_inst;
          rw_addr_d = lsu.in_rw_addr;
          rw_en_d   = lsu.in_rw_en && !is_store(in_op);
          result_d  = '0;
          ale_d     = 1'b0;
          if (in_op == LSU_NONE) begin
            result_d = lsu.in_ex_result;
            state_d  = S_HOLD;
          end else if (in_misaligned) begin
            ale_d   = 1'b1;
            rw_en_d = 1'b0;
            state_d = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end else if ((state_q == S_HOLD) && lsu.ns_ready) begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // Once memory has taken the request its response must still be consumed.
        if (lsu.dmem_req_ready) state_d = lsu.flush ? S_DRAIN : S_WAIT;
        else if (lsu.flush)     state_d = S_IDLE;
      end
      S_WAIT: begin
        if (lsu.dmem_resp_valid) begin
          if (lsu.flush) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_HOLD;
            result_d = is_load(op_q) ? ld_data : '0;
          end
        end else if (lsu.flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (lsu.dmem_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= LSU_NONE;
      addr_q    <= '0;
      pc_q      <= '0;
      sdata_q   <= '0;
      inst_q    <= '0;
      rw_addr_q <= '0;
      rw_en_q   <= 1'b0;
      result_q  <= '0;
      ale_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      pc_q      <= pc_d;
      sdata_q   <= sdata_d;
      inst_q    <= inst_d;
      rw_addr_q <= rw_addr_d;
      rw_en_q   <= rw_en_d;
      result_q  <= result_d;
      ale_q     <= ale_d;
    end
  end
endmodule
